// File: rtl/breath_env.sv
// Breathing-envelope generator: rise / hold-high / fall / hold-low duty ramp stepped on PWM wraps.
// Define BREATH_GAMMA_EN to square-law map the level onto duty; otherwise duty equals the level.
module breath_env #(
  parameter int unsigned STEP_DIV = 16,
  parameter int unsigned HOLD_HI  = 32,
  parameter int unsigned HOLD_LO  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pwm_wrap,
  output logic [7:0] duty,
  output logic       duty_vld,
  output logic [1:0] phase,
  output logic       cycle_done
);

  localparam int unsigned PreW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned HoldMax = (HOLD_HI > HOLD_LO) ? HOLD_HI : HOLD_LO;
  localparam int unsigned HoldW   = (HoldMax > 1) ? $clog2(HoldMax) : 1;

  localparam logic [PreW-1:0]  PreLast = PreW'(STEP_DIV - 1);
  localparam logic [HoldW-1:0] HiLast  = HoldW'(HOLD_HI - 1);
  localparam logic [HoldW-1:0] LoLast  = HoldW'(HOLD_LO - 1);

  localparam logic [1:0] StRise = 2'd0;
  localparam logic [1:0] StHigh = 2'd1;
  localparam logic [1:0] StFall = 2'd2;
  localparam logic [1:0] StLow  = 2'd3;

  logic [PreW-1:0]  pre_q, pre_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [7:0]       level_q, level_d;
  logic [1:0]       phase_q, phase_d;
  logic [7:0]       duty_q, duty_d;
  logic             vld_q;
  logic             done_q, done_d;
  logic             tick, step;

  function automatic logic [7:0] map_duty(input logic [7:0] lvl);
`ifdef BREATH_GAMMA_EN
    logic [15:0] sq;
    sq = 16'(lvl) * 16'(lvl);
    // Square law would top out at 254; pin full scale so full-on stays reachable.
    return (lvl == 8'hFF) ? 8'hFF : sq[15:8];
`else
    return lvl;
`endif
  endfunction

  always_comb begin
    tick    = pwm_wrap & en;
    step    = tick & (pre_q == PreLast);
    pre_d   = pre_q;
    hold_d  = hold_q;
    level_d = level_q;
    phase_d = phase_q;
    done_d  = 1'b0;

    if (tick) begin
      pre_d = step ? '0 : pre_q + 1'b1;
    end

    if (step) begin
      case (phase_q)
        StRise: begin
          level_d = level_q + 8'd1;
          if (level_q == 8'hFE) begin
            phase_d = StHigh;
            hold_d  = '0;
          end
        end
        StHigh: begin
          if (hold_q == HiLast) begin
            phase_d = StFall;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        StFall: begin
          level_d = level_q - 8'd1;
          if (level_q == 8'd1) begin
            phase_d = StLow;
            hold_d  = '0;
          end
        end
        default: begin
          if (hold_q == LoLast) begin
            phase_d = StRise;
            hold_d  = '0;
            done_d  = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      endcase
    end

    // Reloaded on every step, even when the level holds.
    duty_d = step ? map_duty(level_d) : duty_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      hold_q  <= '0;
      level_q <= '0;
      phase_q <= StRise;
      duty_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      phase_q <= phase_d;
      duty_q  <= duty_d;
      vld_q   <= step;
      done_q  <= done_d;
    end
  end

  assign duty       = duty_q;
  assign duty_vld   = vld_q;
  assign phase      = phase_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_breath_env.sv
// Self-checking bench for breath_env: directed scenarios plus random wrap/enable traffic,
// checked against a step-count model of the envelope.
module tb_breath_env;

  localparam int SD  = 2;
  localparam int HH  = 2;
  localparam int HL  = 2;
  localparam int CYC = 510 + HH + HL;

  logic       clk = 1'b0;
  logic       clk_on = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       pwm_wrap = 1'b0;
  logic [7:0] duty;
  logic       duty_vld;
  logic [1:0] phase;
  logic       cycle_done;

  int checks = 0;
  int errors = 0;

  // Model state: total steps since reset and ticks into the current step.
  int steps = 0;
  int ticks = 0;
  int exp_vld = 0;
  int exp_cd = 0;
  int done_seen = 0;

  breath_env #(
    .STEP_DIV(SD),
    .HOLD_HI (HH),
    .HOLD_LO (HL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pwm_wrap  (pwm_wrap),
    .duty      (duty),
    .duty_vld  (duty_vld),
    .phase     (phase),
    .cycle_done(cycle_done)
  );

  always #5 clk = clk_on ? ~clk : 1'b0;

  function automatic int lvl_of(input int s);
    int p;
    p = s % CYC;
    if (p < 255) return p;
    if (p < 255 + HH) return 255;
    if (p < 510 + HH) return 255 - (p - 255 - HH);
    return 0;
  endfunction

  function automatic int ph_of(input int s);
    int p;
    p = s % CYC;
    if (p < 255) return 0;
    if (p < 255 + HH) return 1;
    if (p < 510 + HH) return 2;
    return 3;
  endfunction

  function automatic int fmap(input int l);
`ifdef BREATH_GAMMA_EN
    if (l == 255) return 255;
    return (l * l) / 256;
`else
    return l;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("duty", 32'(duty), fmap(lvl_of(steps)));
    chk("phase", 32'(phase), ph_of(steps));
    chk("duty_vld", 32'(duty_vld), exp_vld);
    chk("cycle_done", 32'(cycle_done), exp_cd);
  endtask

  // One clock with the given inputs; model advances on the edge, outputs sampled 1ns later.
  task automatic cyc(input logic w, input logic e);
    pwm_wrap = w;
    en = e;
    @(posedge clk);
    exp_vld = 0;
    exp_cd = 0;
    if (w && e) begin
      ticks++;
      if (ticks == SD) begin
        ticks = 0;
        steps++;
        exp_vld = 1;
        exp_cd = (steps % CYC == 0) ? 1 : 0;
      end
    end
    #1;
    if (cycle_done === 1'b1) done_seen++;
    check_outputs();
  endtask

  task automatic strobe();
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
  endtask

  // Asserts reset between edges and checks outputs before any further clock edge.
  task automatic do_reset();
    rst = 1'b1;
    steps = 0;
    ticks = 0;
    exp_vld = 0;
    exp_cd = 0;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset with the clock stopped.
    #1 rst = 1'b1;
    #2;
    chk("rst_duty", 32'(duty), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_vld", 32'(duty_vld), 0);
    chk("rst_done", 32'(cycle_done), 0);
    clk_on = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // First step: first strobe gives no pulse, second gives level 1.
    cyc(1'b1, 1'b1);
    chk("first_no_vld", 32'(duty_vld), 0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
`ifdef BREATH_GAMMA_EN
    chk("first_duty", 32'(duty), 0);
`else
    chk("first_duty", 32'(duty), 1);
`endif
    chk("first_vld", 32'(duty_vld), 1);
    cyc(1'b0, 1'b1);
    chk("first_vld_drop", 32'(duty_vld), 0);

    // Complete one full cycle: 1028 strobes in total.
    done_seen = 0;
    for (int i = 2; i < 1028; i++) begin
      strobe();
      if (i == 511) begin
        chk("high_phase", 32'(phase), 1);
        chk("high_duty", 32'(duty), 255);
      end
      if (i == 1025) begin
        chk("low_phase", 32'(phase), 3);
        chk("low_duty", 32'(duty), 0);
      end
    end
    chk("cycle_phase", 32'(phase), 0);
    chk("cycle_done_cnt", 32'(done_seen), 1);

    // Random wrap/enable traffic, including back-to-back wraps.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0));
    end

    // Enable freeze mid-rise at level 100.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 200; i++) strobe();
    chk("freeze_pre", 32'(duty), fmap(100));
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0);
    chk("freeze_duty", 32'(duty), fmap(100));
    chk("freeze_phase", 32'(phase), 0);
    chk("freeze_vld", 32'(duty_vld), 0);
    strobe();
    strobe();
    chk("resume_duty", 32'(duty), fmap(101));

    // Gamma points along the rise.
    for (int i = 0; i < 2000 && lvl_of(steps) != 128; i++) strobe();
`ifdef BREATH_GAMMA_EN
    chk("gamma_128", 32'(duty), 64);
`else
    chk("gamma_128", 32'(duty), 128);
`endif
    for (int i = 0; i < 2000 && lvl_of(steps) != 255; i++) strobe();
    chk("gamma_255", 32'(duty), 255);

    // Reset mid-fall at level 40.
    for (int i = 0; i < 2000 && !(ph_of(steps) == 2 && lvl_of(steps) == 40); i++) strobe();
    chk("fall_40", 32'(duty), fmap(40));
    do_reset();
    chk("rst_fall_duty", 32'(duty), 0);
    chk("rst_fall_phase", 32'(phase), 0);
    strobe();
    strobe();
    chk("post_rst_duty", 32'(duty), fmap(1));

    for (int i = 0; i < 2000 && lvl_of(steps) != 16; i++) strobe();
`ifdef BREATH_GAMMA_EN
    chk("gamma_16", 32'(duty), 1);
`else
    chk("gamma_16", 32'(duty), 16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/breath_env.md
# breath_env

Breathing-envelope generator that feeds the LED PWM comparator. It produces the 8-bit duty value the PWM stage compares against its free-running counter. The envelope is a four-phase cycle: rise, hold-high, fall, hold-low. The duty value only advances on PWM period-wrap strobes, so the comparator never sees a duty change mid-period. Sits directly upstream of the PWM output stage, in the PLL `c0` clock domain.

## Interface

Parameters:
- `STEP_DIV`, 16: PWM periods (accepted `pwm_wrap` strobes) per envelope step; legal range ≥1.
- `HOLD_HI`, 32: steps spent at full brightness; legal range ≥1.
- `HOLD_LO`, 32: steps spent dark; legal range ≥1.

Ports:
- `clk`  in  1  PLL core clock (`c0` domain).
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  envelope run enable; when low, all state freezes.
- `pwm_wrap`  in  1  one-cycle strobe from the PWM stage at counter wrap.
- `duty`  out  8  duty value to the PWM comparator (registered).
- `duty_vld`  out  1  one-cycle pulse: `duty` was reloaded on the preceding edge.
- `phase`  out  2  current state: 0=RISE, 1=HIGH, 2=FALL, 3=LOW.
- `cycle_done`  out  1  one-cycle pulse on the LOW→RISE transition.

## Operation

- `tick = pwm_wrap & en`. `pwm_wrap` is ignored while `en` is low.
- Prescaler counts ticks 0..STEP_DIV-1 (width `$clog2(STEP_DIV)`, minimum 1 bit).
  - A tick while the prescaler is at STEP_DIV-1 is a **step**; the prescaler returns to 0.
- Internal 8-bit `level`, plus a hold counter wide enough for max(HOLD_HI, HOLD_LO).
- State machine, evaluated on step only:
  - RISE: `level+1`. If the new level is 255, go to HIGH and clear the hold counter.
  - HIGH: hold counter +1. On the HOLD_HI-th step, go to FALL and clear the hold counter; level stays 255.
  - FALL: `level-1`. If the new level is 0, go to LOW and clear the hold counter.
  - LOW: hold counter +1. On the HOLD_LO-th step, go to RISE, clear the hold counter, and pulse `cycle_done`.
- Level never wraps: 255 is reached only in RISE and 0 only in FALL, and each forces the state change on the same edge.
- One full cycle is (510 + HOLD_HI + HOLD_LO) steps, which is (510 + HOLD_HI + HOLD_LO) × STEP_DIV ticks.
- `duty` loads f(next level) on every step edge, including HIGH/LOW steps where the value does not change. `duty_vld` is high for the following cycle.
- `en` low: prescaler, hold counter, level, phase and duty all hold. Re-asserting `en` resumes exactly where it stopped.
- Reset values: `duty`=0, `duty_vld`=0, `phase`=0 (RISE), `cycle_done`=0, level=0, prescaler=0, hold=0.
- Asynchronous reset mid-operation forces all reset values immediately, with no clock needed. The first step after release goes from level 0 to 1.

## Timing

- Latency is 1 clock: a step-qualifying `pwm_wrap` in cycle N gives the new `duty`, `phase`, `duty_vld`=1 and (if applicable) `cycle_done`=1 after the edge ending cycle N.
- `duty_vld` and `cycle_done` each stay high for exactly one cycle.
  - Back-to-back `pwm_wrap` with STEP_DIV=1 gives back-to-back `duty_vld`.
- Because `duty` only changes right after a wrap, the PWM period that starts on that wrap sees the new value from its second clock onward. This is acceptable; no further alignment is required.

## Configuration

- `BREATH_GAMMA_EN` defined: f(L) = (L×L)>>8, except L=255 maps to 255. This gives square-law perceptual correction; full-on and full-off are both reachable.
- Not defined: f(L) = L (linear).
- The macro affects only the `duty` mapping. State, phase and pulse timing are identical in both builds.

## Test plan

All scenarios use STEP_DIV=2 and HOLD_HI=HOLD_LO=2.

- Reset: assert `rst` with no clock running → `duty`=0, `phase`=0, `duty_vld`=0, `cycle_done`=0.
- First step: `en`=1, two `pwm_wrap` strobes → one cycle after the 2nd strobe, `duty`=1 (linear) or 0 (gamma) and `duty_vld`=1 for one cycle. The 1st strobe produces no `duty_vld`.
- Full cycle: 1028 strobes → `phase` follows RISE (510 strobes), HIGH with `duty`=255 (4), FALL (510), LOW with `duty`=0 (4). `cycle_done` pulses once after strobe 1028 and `phase` returns to 0.
- Enable freeze: mid-RISE at level 100, set `en`=0 and send 50 strobes → `duty`, `phase` and `duty_vld` unchanged. Re-enable and send 2 strobes → level 101.
- Reset mid-FALL: assert `rst` at level 40 → `duty`=0 and `phase`=0 within the same cycle, with no clock edge. After release, 2 strobes give level 1.
- Gamma check (`BREATH_GAMMA_EN` defined): level 128 → `duty`=64; level 16 → 1; level 255 → 255. Without the macro, level 128 → `duty`=128.
